// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared Fetch-side types: the branch update record sent from
//                execute/writeback to Fetch and its all-zero reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef struct packed {
        logic        taken;
        logic        mispredicted;
        logic        unconditional;
        logic [31:0] addr;
        logic [31:0] target;
    } branch_update_t;

    localparam branch_update_t c_branch_update_reset = '0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/branch_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : branch_update_queue
//  Description : In-order FIFO of branch training updates. Accepts up to two
//                pushes per cycle (push0 is older than push1) and one pop.
//                Callers must never push past capacity.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_update_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0_i,
    input  branch_update_t             push0_data_i,
    input  logic                       push1_i,
    input  branch_update_t             push1_data_i,
    input  logic                       pop_i,
    output branch_update_t             head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    branch_update_t         mem_q [DEPTH];
    logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]     count_q,  count_d;
    logic [c_ptr_w-1:0]     w_wr1_ptr;

    // push1 lands in the slot after push0 when both fire, else at the tail
    assign w_wr1_ptr = wr_ptr_q + c_ptr_w'(push0_i);

    // Next pointer/occupancy values; pointers wrap naturally at power-of-2 DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q + c_ptr_w'(push0_i) + c_ptr_w'(push1_i);
        rd_ptr_d = rd_ptr_q + c_ptr_w'(pop_i);
        count_d  = count_q + c_cnt_w'(push0_i) + c_cnt_w'(push1_i) - c_cnt_w'(pop_i);
    end

    // Storage array: contents need no reset because the count gates validity
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q]  <= push0_data_i;
        if (push1_i) mem_q[w_wr1_ptr] <= push1_data_i;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule : branch_update_queue
`default_nettype wire

// File: rtl/branch_update_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : branch_update_arbiter
//  Description : Merges two execute-side branch update ports (port 0 older)
//                into one registered update stream for Fetch. Mispredict
//                redirects bypass the training queue; training updates drain
//                in order, one per cycle. Younger same-cycle requests behind a
//                port 0 mispredict are wrong-path and dropped (and counted).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_update_arbiter
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic                       req0_taken,
    input  logic                       req0_mispredicted,
    input  logic                       req0_unconditional,
    input  logic [31:0]                req0_addr,
    input  logic [31:0]                req0_target,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic                       req1_taken,
    input  logic                       req1_mispredicted,
    input  logic                       req1_unconditional,
    input  logic [31:0]                req1_addr,
    input  logic [31:0]                req1_target,

    output logic                       branch_update_valid,
    output logic                       branch_update_taken,
    output logic                       branch_update_mispredicted,
    output logic                       branch_update_unconditional,
    output logic [31:0]                branch_update_addr,
    output logic [31:0]                branch_update_target,

    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int c_qc_w = $clog2(DEPTH) + 1;

    branch_update_t         w_req0, w_req1, w_head;
    branch_update_t         w_push0_data, w_push1_data;
    branch_update_t         out_q, out_d;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       drop_q;
    logic [c_qc_w-1:0]      w_count;
    logic                   w_empty;
    logic                   w_acc0, w_acc1_raw, w_acc1, w_drop;
    logic                   w_push0, w_push1, w_pop;

    assign w_req0 = '{taken: req0_taken, mispredicted: req0_mispredicted,
                      unconditional: req0_unconditional, addr: req0_addr,
                      target: req0_target};
    assign w_req1 = '{taken: req1_taken, mispredicted: req1_mispredicted,
                      unconditional: req1_unconditional, addr: req1_addr,
                      target: req1_target};

    // Ready uses current occupancy only; port 1 needs room for both ports
    assign req0_ready = req0_mispredicted | (w_count <  c_qc_w'(DEPTH));
    assign req1_ready = req1_mispredicted | (w_count <= c_qc_w'(DEPTH - 2));

    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1_raw = req1_valid & req1_ready;
    assign w_drop     = w_acc0 & req0_mispredicted & w_acc1_raw;
    assign w_acc1     = w_acc1_raw & ~w_drop;

    // Output selection and queue push/pop: mispredicts, then queue head,
    // then fresh training updates; leftovers are queued oldest first
    always_comb begin
        valid_d      = 1'b0;
        out_d        = out_q;
        w_pop        = 1'b0;
        w_push0      = 1'b0;
        w_push0_data = w_req0;
        w_push1      = 1'b0;
        w_push1_data = w_req1;
        if (w_acc0 && req0_mispredicted) begin
            valid_d = 1'b1;
            out_d   = w_req0;
        end else if (w_acc1 && req1_mispredicted) begin
            valid_d = 1'b1;
            out_d   = w_req1;
            w_push0 = w_acc0;
        end else if (!w_empty) begin
            valid_d = 1'b1;
            out_d   = w_head;
            w_pop   = 1'b1;
            w_push0 = w_acc0;
            w_push1 = w_acc1;
        end else if (w_acc0) begin
            valid_d      = 1'b1;
            out_d        = w_req0;
            w_push0      = w_acc1;
            w_push0_data = w_req1;
        end else if (w_acc1) begin
            valid_d = 1'b1;
            out_d   = w_req1;
        end
    end

    // Registered output to Fetch; fields hold when no update is presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= c_branch_update_reset;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    // Saturating count of wrong-path requests dropped behind a port 0 redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (w_drop && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    branch_update_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (w_push0),
        .push0_data_i (w_push0_data),
        .push1_i      (w_push1),
        .push1_data_i (w_push1_data),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_count),
        .empty_o      (w_empty)
    );

    assign branch_update_valid         = valid_q;
    assign branch_update_taken         = out_q.taken;
    assign branch_update_mispredicted  = out_q.mispredicted;
    assign branch_update_unconditional = out_q.unconditional;
    assign branch_update_addr          = out_q.addr;
    assign branch_update_target        = out_q.target;
    assign queue_count                 = w_count;
    assign drop_count                  = drop_q;

endmodule : branch_update_arbiter
`default_nettype wire

// File: tb/tb_branch_update_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_update_arbiter
//  Description : Scoreboard bench for branch_update_arbiter. Stimulus pushes
//                the expected Fetch updates; a negedge monitor pops/compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_update_arbiter;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            v0 = 1'b0, v1 = 1'b0;
    branch_update_t  r0 = '0, r1 = '0;
    logic            rdy0, rdy1;
    logic            bu_valid, bu_taken, bu_mis, bu_unc;
    logic [31:0]     bu_addr, bu_target;
    logic [2:0]      qcount;
    logic [CNT_W-1:0] dcount;

    branch_update_t  exp_q [$];
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    branch_update_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req0_valid                  (v0),
        .req0_ready                  (rdy0),
        .req0_taken                  (r0.taken),
        .req0_mispredicted           (r0.mispredicted),
        .req0_unconditional          (r0.unconditional),
        .req0_addr                   (r0.addr),
        .req0_target                 (r0.target),
        .req1_valid                  (v1),
        .req1_ready                  (rdy1),
        .req1_taken                  (r1.taken),
        .req1_mispredicted           (r1.mispredicted),
        .req1_unconditional          (r1.unconditional),
        .req1_addr                   (r1.addr),
        .req1_target                 (r1.target),
        .branch_update_valid         (bu_valid),
        .branch_update_taken         (bu_taken),
        .branch_update_mispredicted  (bu_mis),
        .branch_update_unconditional (bu_unc),
        .branch_update_addr          (bu_addr),
        .branch_update_target        (bu_target),
        .queue_count                 (qcount),
        .drop_count                  (dcount)
    );

    function automatic branch_update_t mk(input logic t, input logic m, input logic u,
                                          input logic [31:0] a, input logic [31:0] tg);
        branch_update_t b;
        b.taken = t; b.mispredicted = m; b.unconditional = u; b.addr = a; b.target = tg;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 1'b0; v1 = 1'b0; r0 = '0; r1 = '0;
    endtask

    // Monitor: every presented update must match the oldest expectation
    always @(negedge clk) begin
        if (bu_valid) begin
            branch_update_t act;
            act = mk(bu_taken, bu_mis, bu_unc, bu_addr, bu_target);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_update: got %h expected none", act);
            end else begin
                branch_update_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL update_order: got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish expected <100000");
        $fatal(1, "watchdog");
    end

    initial begin
        branch_update_t ta, tb2, tc, m;
        branch_update_t t [4];
        branch_update_t mm [4];

        // ---------------- reset state
        #1 rst = 1'b1;
        #1;
        chk("reset_valid", {31'b0, bu_valid}, 32'd0);
        chk("reset_addr", bu_addr, 32'd0);
        chk("reset_target", bu_target, 32'd0);
        chk("reset_qcount", {29'b0, qcount}, 32'd0);
        chk("reset_drop", {16'b0, dcount}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // ---------------- single training update, empty queue
        ta = mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
        v0 = 1'b1; r0 = ta; exp_q.push_back(ta);
        step(); idle();
        chk("t1_valid", {31'b0, bu_valid}, 32'd1);
        chk("t1_addr", bu_addr, 32'h100);
        chk("t1_qcount", {29'b0, qcount}, 32'd0);
        step();
        chk("t1_idle_valid", {31'b0, bu_valid}, 32'd0);
        chk("t1_hold_addr", bu_addr, 32'h100);

        // ---------------- dual training with queue holding A
        m   = mk(1'b1, 1'b1, 1'b0, 32'h500, 32'h600);
        ta  = mk(1'b0, 1'b0, 1'b0, 32'h1000, 32'h1004);
        tb2 = mk(1'b1, 1'b0, 1'b1, 32'h2000, 32'h2400);
        tc  = mk(1'b1, 1'b0, 1'b0, 32'h3000, 32'h3800);
        v0 = 1'b1; r0 = ta; v1 = 1'b1; r1 = m;
        exp_q.push_back(m); exp_q.push_back(ta);
        step();
        chk("t2_qcount_1", {29'b0, qcount}, 32'd1);
        r0 = tb2; r1 = tc;
        chk("t2_ready1", {31'b0, rdy1}, 32'd1);
        exp_q.push_back(tb2); exp_q.push_back(tc);
        step(); idle();
        chk("t2_qcount_2", {29'b0, qcount}, 32'd2);
        step();
        chk("t2_qcount_3", {29'b0, qcount}, 32'd1);
        step();
        chk("t2_qcount_4", {29'b0, qcount}, 32'd0);
        step();

        // ---------------- mispredict bypass with A,B queued
        mm[0] = mk(1'b1, 1'b1, 1'b0, 32'h700, 32'h704);
        mm[1] = mk(1'b0, 1'b1, 1'b0, 32'h708, 32'h70c);
        m     = mk(1'b1, 1'b1, 1'b0, 32'h300, 32'h40);
        ta    = mk(1'b1, 1'b0, 1'b0, 32'hA00, 32'hA40);
        tb2   = mk(1'b0, 1'b0, 1'b0, 32'hB00, 32'hB04);
        v0 = 1'b1; r0 = ta; v1 = 1'b1; r1 = mm[0];
        exp_q.push_back(mm[0]);
        step();
        r0 = tb2; r1 = mm[1];
        exp_q.push_back(mm[1]);
        step();
        chk("t3_qcount_ab", {29'b0, qcount}, 32'd2);
        v0 = 1'b0; r0 = '0; r1 = m;
        exp_q.push_back(m); exp_q.push_back(ta); exp_q.push_back(tb2);
        step(); idle();
        chk("t3_mis_flag", {31'b0, bu_mis}, 32'd1);
        chk("t3_mis_target", bu_target, 32'h40);
        chk("t3_qcount_kept", {29'b0, qcount}, 32'd2);
        step(); step();
        chk("t3_drained", {29'b0, qcount}, 32'd0);
        step();

        // ---------------- wrong-path drop
        m  = mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h80);
        tc = mk(1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF);
        v0 = 1'b1; r0 = m; v1 = 1'b1; r1 = tc;
        exp_q.push_back(m);
        #1;
        chk("t4_ready1", {31'b0, rdy1}, 32'd1);
        step(); idle();
        chk("t4_addr", bu_addr, 32'h10);
        chk("t4_drop", {16'b0, dcount}, 32'd1);
        chk("t4_qcount", {29'b0, qcount}, 32'd0);
        step();

        // ---------------- full backpressure
        for (int k = 0; k < 4; k++) begin
            t[k]  = mk(k[0], 1'b0, 1'b0, 32'h4000 + 32'(k) * 4, 32'h5000 + 32'(k) * 4);
            mm[k] = mk(1'b1, 1'b1, k[1], 32'h6000 + 32'(k) * 4, 32'h7000 + 32'(k) * 4);
        end
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b1; r0 = t[k]; v1 = 1'b1; r1 = mm[k];
            if (k == 3) begin
                chk("t5_qcount_3", {29'b0, qcount}, 32'd3);
                r1.mispredicted = 1'b0;
                #1;
                chk("t5_ready1_at3", {31'b0, rdy1}, 32'd0);
                chk("t5_ready0_at3", {31'b0, rdy0}, 32'd1);
                r1 = mm[k];
                #1;
            end
            exp_q.push_back(mm[k]);
            step();
        end
        idle();
        chk("t5_qcount_full", {29'b0, qcount}, 32'd4);
        v0 = 1'b1; r0 = mk(1'b1, 1'b0, 1'b0, 32'h9000, 32'h9004);
        #1;
        chk("t5_ready0_full_train", {31'b0, rdy0}, 32'd0);
        m = mk(1'b0, 1'b1, 1'b1, 32'h9100, 32'h9200);
        r0 = m;
        #1;
        chk("t5_ready0_full_mis", {31'b0, rdy0}, 32'd1);
        exp_q.push_back(m);
        step(); idle();
        chk("t5_qcount_still_full", {29'b0, qcount}, 32'd4);
        for (int k = 0; k < 4; k++) exp_q.push_back(t[k]);
        for (int k = 0; k < 4; k++) step();
        chk("t5_drained", {29'b0, qcount}, 32'd0);
        step();

        // ---------------- reset mid-drain with 3 queued entries
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1; r0 = mk(1'b1, 1'b0, 1'b0, 32'hE000 + 32'(k), 32'hE100);
            v1 = 1'b1; r1 = mk(1'b1, 1'b1, 1'b0, 32'hF000 + 32'(k), 32'hF100);
            exp_q.push_back(r1);
            step();
        end
        idle();
        @(negedge clk);
        #1;
        chk("t6_qcount_pre", {29'b0, qcount}, 32'd3);
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t6_valid_async", {31'b0, bu_valid}, 32'd0);
        chk("t6_qcount_async", {29'b0, qcount}, 32'd0);
        chk("t6_drop_async", {16'b0, dcount}, 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        ta = mk(1'b0, 1'b0, 1'b1, 32'h1234, 32'h5678);
        v0 = 1'b1; r0 = ta; exp_q.push_back(ta);
        step(); idle();
        chk("t6_post_addr", bu_addr, 32'h1234);
        chk("t6_post_qcount", {29'b0, qcount}, 32'd0);
        step(); step();

        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_branch_update_arbiter
`default_nettype wire

// File: doc/branch_update_arbiter.md
Name: branch_update_arbiter

Overview:
Merges branch-resolution updates from two execute-side requesters (port 0 = older in program order, port 1 = younger) into the single per-cycle branch_update_* stream consumed by Fetch.
Mispredict redirects bypass queued training updates so redirect latency stays at 1 cycle. Non-mispredicted (BTB/BPU training) updates are buffered in a small in-order queue and drained one per cycle. Sits between the execute/writeback stage and Fetch.

Parameters:
DEPTH, 4, training-queue entries (power of 2, >=2)
CNT_W, 16, width of wrong-path drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  port 0 update valid
req0_ready  out  1  port 0 accepted when valid&ready
req0_taken / req0_mispredicted / req0_unconditional  in  1 each  port 0 branch outcome
req0_addr  in  32  port 0 branch PC
req0_target  in  32  port 0 resolved next PC
req1_valid / req1_ready / req1_taken / req1_mispredicted / req1_unconditional / req1_addr / req1_target  same as port 0, for port 1
branch_update_valid  out  1  registered update to Fetch
branch_update_taken / branch_update_mispredicted / branch_update_unconditional  out  1 each  registered fields
branch_update_addr / branch_update_target  out  32 each  registered fields
queue_count  out  $clog2(DEPTH)+1  current occupancy
drop_count  out  CNT_W  saturating count of wrong-path drops

Behaviour:
- Reset (async, rst=1): branch_update_* all 0, queue empty, queue_count=0, drop_count=0. Reset mid-operation discards all queued entries, with no partial output.
- free = DEPTH - queue_count, using current-cycle occupancy with no credit for same-cycle pop.
- req0_ready = req0_mispredicted | (free>=1); req1_ready = req1_mispredicted | (free>=2). Mispredicts are always accepted.
- Accepted = valid & ready. Wrong-path rule: if port 0 accepts a mispredict, port 1's same-cycle request is accepted (ready as defined) but discarded, and drop_count increments by 1, saturating at all-ones.
- Output register selection each cycle, priority order:
  1. accepted mispredict (port 0 over port 1);
  2. queue head (popped);
  3. accepted non-mispredict req0;
  4. accepted non-mispredict req1.
- Accepted non-mispredict requests not selected for output are pushed to the queue. Port 0 is pushed before port 1 (in-order).
- If no candidate exists, branch_update_valid=0 and the other outputs hold their last values.
- Latency: 1 cycle from accept to branch_update_valid for a mispredict, or for a training update arriving at an empty queue. Otherwise the update waits behind older entries.
- Port 1 mispredict with port 0 non-mispredict: port 0 entry is pushed/kept (older, valid); port 1 goes to output.
- Queued entries are never flushed by a mispredict. They are older than it, and their training remains valid.
- Training starves while mispredicts arrive every cycle; this is acceptable.
- Full: ready drops per the rule above, and no entry is ever overwritten. Pointers wrap modulo DEPTH.
- Queue pushes up to 2 and pops up to 1 per cycle. queue_count is updated as count + pushes - pop.

Decomposition:
- Shared package fetch_pkg: typedef branch_update_t {taken, mispredicted, unconditional, addr[31:0], target[31:0]}; constant RESET-zero value for branch_update_t.
- Sub-module branch_update_queue: DEPTH-entry FIFO of branch_update_t with dual push (push0 before push1), single pop, count output.
- The arbiter holds the selection logic, the output register and drop_count.

Test Plan:
- Single training update: req0 {addr=0x100, target=0x200, taken=1, mispredicted=0} into empty queue -> next cycle branch_update_valid=1, addr=0x100, target=0x200; queue_count stays 0.
- Dual training, queue non-empty: queue holds A; req0=B and req1=C the same cycle -> outputs A, B, C on 3 consecutive cycles; queue_count goes 1, 2, 1, 0.
- Mispredict bypass: queue holds A, B; req1 mispredict M {addr=0x300, target=0x40} -> next cycle output M (mispredicted=1), then A, then B.
- Wrong-path drop: req0 mispredict {addr=0x10, target=0x80}, req1 training at the same time -> output is the req0 update, req1 discarded, drop_count=1, queue_count unchanged.
- Full backpressure, DEPTH=4: fill to 4 with back-to-back mispredicts blocking drain -> req0_ready=0 for non-mispredict while a req0 mispredict still gets ready=1. With 3 entries, req1_ready=0 and req0_ready=1.
- Reset mid-drain: assert rst with queue_count=3 -> branch_update_valid=0, queue_count=0 immediately (async). After deassert, no stale entry is ever output.
